// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Define MMIO_UART_TX_PARITY_EN to build the optional parity bit (CTRL bits 2/3).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_next;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    count_byte;
    logic          overflow, enable;
    logic [15:0]   baud_div;
    logic [7:0]    shift_reg, shift_next;
    logic [15:0]   bit_cnt, cnt_next, div_lat, div_lat_next;
    logic [2:0]    bit_idx, idx_next;
    logic          tx_next, busy_next;
    logic          sel;
    logic [1:0]    offset;
    logic          push_req, push, pop, full, empty, period_end;
    logic          wr_baud, wr_ctrl;
    logic [1:0]    ctrl_hi;
    logic          unused_bits;

`ifdef MMIO_UART_TX_PARITY_EN
    logic parity_en, odd, par_lat, par_lat_next, par_bit, par_bit_next;
`endif

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:2];
    assign push_req   = mem_write & sel & (offset == 2'd0);
    assign wr_baud    = mem_write & sel & (offset == 2'd2);
    assign wr_ctrl    = mem_write & sel & (offset == 2'd3);
    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign push       = push_req & ~full;
    assign period_end = (bit_cnt == 16'd0);
    assign count_byte = 8'(count);
    assign unused_bits = ^{addr[1:0], write_data[31:16]};

`ifdef MMIO_UART_TX_PARITY_EN
    assign ctrl_hi = {odd, parity_en};
`else
    assign ctrl_hi = 2'b00;
`endif

    // Configuration registers and sticky overflow; a setting push beats a clear request
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div <= DEFAULT_DIV;
            enable   <= 1'b1;
            overflow <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_en <= 1'b0;
            odd       <= 1'b0;
`endif
        end else begin
            if (wr_baud)
                baud_div <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
            if (wr_ctrl) begin
                enable <= write_data[0];
`ifdef MMIO_UART_TX_PARITY_EN
                parity_en <= write_data[2];
                odd       <= write_data[3];
`endif
            end
            if (push_req && full)
                overflow <= 1'b1;
            else if (wr_ctrl && write_data[1])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= write_data[7:0];
    end

    // State register; tx and tx_busy are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            par_lat <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            tx_busy <= busy_next;
`ifdef MMIO_UART_TX_PARITY_EN
            par_lat <= par_lat_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shift_reg <= shift_next;
        bit_cnt   <= cnt_next;
        bit_idx   <= idx_next;
        div_lat   <= div_lat_next;
`ifdef MMIO_UART_TX_PARITY_EN
        par_bit   <= par_bit_next;
`endif
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: if (period_end) state_next = DATA;
            DATA: begin
                if (period_end && bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    state_next = par_lat ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: if (period_end) state_next = STOP;
`endif
            STOP: begin
                // Chaining straight into START keeps frames back-to-back
                if (period_end) begin
                    if (enable && !empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shift_next   = shift_reg;
        cnt_next     = bit_cnt;
        idx_next     = bit_idx;
        div_lat_next = div_lat;
`ifdef MMIO_UART_TX_PARITY_EN
        par_lat_next = par_lat;
        par_bit_next = par_bit;
`endif
        if (pop) begin
            shift_next   = fifo_mem[rd_ptr];
            div_lat_next = baud_div;
            cnt_next     = baud_div - 16'd1;
            idx_next     = 3'd0;
`ifdef MMIO_UART_TX_PARITY_EN
            par_lat_next = parity_en;
            par_bit_next = (^fifo_mem[rd_ptr]) ^ odd;
`endif
        end else if (state != IDLE) begin
            if (period_end) begin
                cnt_next = div_lat - 16'd1;
                if (state == DATA) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    idx_next   = bit_idx + 3'd1;
                end
            end else begin
                cnt_next = bit_cnt - 16'd1;
            end
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY:  tx_next = par_bit_next;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_comb begin
        read_data = 32'd0;
        if (sel) begin
            case (offset)
                2'd1:    read_data = {16'd0, count_byte, 4'd0, overflow, empty, full, tx_busy};
                2'd2:    read_data = {16'd0, baud_div};
                2'd3:    read_data = {28'd0, ctrl_hi, 1'b0, enable};
                default: read_data = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed steps plus randomized bursts
// compared against a frame-level model built from queues of expected line bits.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        mem_write = 1'b0;
    logic [31:0] read_data;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         exp_q[$];
    logic       mdl_ovf = 1'b0;
    logic       mdl_pen = 1'b0;
    logic       mdl_odd = 1'b0;
    int         mdl_div = 868;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .mem_write(mem_write), .read_data(read_data), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        write_data = d;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    task automatic store(input logic [7:0] b);
        if (q.size() == DEPTH) mdl_ovf = 1'b1;
        else q.push_back(b);
        wr(BASE, {24'd0, b});
    endtask

    function automatic logic [31:0] ctrl_val(input logic en);
        return {28'd0, mdl_odd, mdl_pen, 1'b0, en};
    endfunction

    function automatic logic [31:0] status_exp(input logic busy);
        logic [7:0] c;
        c = 8'(q.size());
        return {16'd0, c, 4'd0, mdl_ovf, (q.size() == 0), (q.size() == DEPTH), busy};
    endfunction

    // Expected per-cycle line levels for the next nfr queued bytes
    task automatic build(input int nfr, input int d0, input int d1);
        logic [7:0] b;
        int d;
        bit sym[$];
        exp_q.delete();
        for (int f = 0; f < nfr; f++) begin
            b = q.pop_front();
            d = (f == 0) ? d0 : d1;
            sym.delete();
            sym.push_back(1'b0);
            for (int i = 0; i < 8; i++) sym.push_back(b[i]);
            if (mdl_pen) sym.push_back((^b) ^ mdl_odd);
            sym.push_back(1'b1);
            foreach (sym[s]) repeat (d) exp_q.push_back(sym[s]);
        end
    endtask

    task automatic check_stream(input string tag, input int mode,
                                input logic [31:0] wa, input logic [31:0] wd);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (mode != 0 && k == 2) begin
                addr = wa;
                write_data = wd;
                mem_write = 1'b1;
            end
            tick();
            mem_write = 1'b0;
            chk({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_q[k]});
            chk({tag, "_busy"}, {31'd0, tx_busy}, 32'd1);
        end
        tick();
        chk({tag, "_busy_end"}, {31'd0, tx_busy}, 32'd0);
        chk({tag, "_tx_end"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        int n, mode, new_div;
        logic toggled;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        rd("rst_status", BASE + 32'h4, 32'h0000_0004);
        rd("rst_baud", BASE + 32'h8, 32'd868);
        rd("rst_ctrl", BASE + 32'hC, 32'd1);
        rd("rst_txdata", BASE, 32'd0);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);

        // Single frame 0xA5 at two cycles per bit
        wr(BASE + 32'h8, 32'd2);
        mdl_div = 2;
        store(8'hA5);
        build(1, 2, 2);
        check_stream("a5", 0, 32'd0, 32'd0);

        // Disabled FIFO fills and overflows, then drains back-to-back
        wr(BASE + 32'hC, 32'd0);
        wr(BASE + 32'h8, 32'd1);
        mdl_div = 1;
        for (int i = 1; i <= 5; i++) store(8'(i));
        rd("fill_status", BASE + 32'h4, status_exp(1'b0));
        repeat (3) tick();
        chk("fill_tx_idle", {31'd0, tx}, 32'd1);
        build(4, 1, 1);
        wr(BASE + 32'hC, ctrl_val(1'b1));
        check_stream("burst", 0, 32'd0, 32'd0);
        rd("drain_status", BASE + 32'h4, status_exp(1'b0));
        wr(BASE + 32'hC, 32'd3);
        mdl_ovf = 1'b0;
        rd("ovf_clear", BASE + 32'h4, status_exp(1'b0));
        rd("ctrl_after_clear", BASE + 32'hC, 32'd1);

        // Reset mid-frame flushes the FIFO and returns the line high
        wr(BASE + 32'h8, 32'd4);
        store(8'h55);
        store(8'h33);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        reset = 1'b0;
        q.delete();
        mdl_ovf = 1'b0;
        mdl_div = 868;
        rd("midrst_status", BASE + 32'h4, status_exp(1'b0));
        rd("midrst_baud", BASE + 32'h8, 32'd868);
        toggled = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx !== 1'b1) toggled = 1'b1;
        end
        chk("midrst_no_toggle", {31'd0, toggled}, 32'd0);

        // Address decode outside the window and divisor floor
        wr(BASE + 32'h10, 32'h77);
        rd("oow_status", BASE + 32'h4, status_exp(1'b0));
        repeat (3) tick();
        chk("oow_tx", {31'd0, tx}, 32'd1);
        rd("oow_read", BASE + 32'h2C, 32'd0);
        rd("byte_offset_ignored", BASE + 32'h9, 32'd868);
        wr(BASE + 32'h8, 32'd0);
        mdl_div = 1;
        rd("baud_zero", BASE + 32'h8, 32'd1);
`ifndef MMIO_UART_TX_PARITY_EN
        wr(BASE + 32'hC, 32'hD);
        rd("ctrl_hi_ignored", BASE + 32'hC, 32'd1);
`endif

        // Randomized bursts, with optional mid-frame divisor change or disable
        for (int it = 0; it < 8; it++) begin
            wr(BASE + 32'hC, ctrl_val(1'b0));
            mdl_div = $urandom_range(1, 3);
            wr(BASE + 32'h8, 32'(mdl_div));
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) store(8'($urandom));
            rd("rnd_status", BASE + 32'h4, status_exp(1'b0));
            mode = $urandom_range(0, 2);
            new_div = $urandom_range(1, 3);
            build((mode == 2) ? 1 : n, mdl_div, (mode == 1) ? new_div : mdl_div);
            wr(BASE + 32'hC, ctrl_val(1'b1));
            if (mode == 1)
                check_stream("rnd_div", 1, BASE + 32'h8, 32'(new_div));
            else if (mode == 2)
                check_stream("rnd_dis", 2, BASE + 32'hC, ctrl_val(1'b0));
            else
                check_stream("rnd", 0, 32'd0, 32'd0);
            if (mode == 1) mdl_div = new_div;
            rd("rnd_after", BASE + 32'h4, status_exp(1'b0));
            if (q.size() != 0) begin
                build(q.size(), mdl_div, mdl_div);
                wr(BASE + 32'hC, ctrl_val(1'b1));
                check_stream("rnd_rest", 0, 32'd0, 32'd0);
            end
        end

`ifdef MMIO_UART_TX_PARITY_EN
        // Even and odd parity on 0x07
        wr(BASE + 32'h8, 32'd1);
        mdl_div = 1;
        mdl_pen = 1'b1;
        mdl_odd = 1'b0;
        wr(BASE + 32'hC, 32'h5);
        rd("par_ctrl", BASE + 32'hC, 32'h5);
        store(8'h07);
        build(1, 1, 1);
        check_stream("par_even", 0, 32'd0, 32'd0);
        mdl_odd = 1'b1;
        wr(BASE + 32'hC, 32'hD);
        store(8'h07);
        build(1, 1, 1);
        check_stream("par_odd", 0, 32'd0, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
